fetch_ctrl: RTL and testbench

//  Sequences instruction fetch for the rv32i pipeline. Drives stallF/FlushF/PCNext into fetch_stage,

---
 rtl/rv32i_pkg.sv | 15 +
 rtl/fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i pipeline definitions: datapath width, the canonical NOP and the fetch FSM states.
package rv32i_pkg;

    localparam int unsigned DPW       = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one-outstanding imem requests, decode-stall hold, redirect handling.
// Optional stall-cycle counter port perf_stall_cnt when FETCH_STALL_CNT_EN is defined.
module fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned IW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DPW-1:0] PCF,
    input  logic           PCSrcE,
    input  logic [DPW-1:0] PCTargetE,
    input  logic           stall_hz,
    output logic           imem_req_valid,
    input  logic           imem_req_ready,
    output logic [DPW-1:0] imem_req_addr,
    input  logic           imem_rsp_valid,
    input  logic [IW-1:0]  imem_rsp_data,
    output logic [DPW-1:0] PCNext,
    output logic           stallF,
    output logic           FlushF,
    output logic [IW-1:0]  InstrF,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0]    perf_stall_cnt,
`endif
    output logic           InstrF_valid
);

    fetch_state_t   state_q, state_d;
    logic [DPW-1:0] addr_q, addr_d;
    logic [IW-1:0]  hold_q, hold_d;
    logic           kill_q, kill_d;   // redirect seen while the request was still unaccepted
    logic           enter_req;

    assign PCNext        = PCSrcE ? PCTargetE : PCF + DPW'(4);
    assign imem_req_addr = addr_q;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        hold_d         = hold_q;
        kill_d         = kill_q;
        enter_req      = 1'b0;
        imem_req_valid = 1'b0;
        stallF         = 1'b1;
        FlushF         = 1'b0;
        InstrF         = IW'(INSTR_NOP);
        InstrF_valid   = 1'b0;

        unique case (state_q)
            BOOT: begin
                FlushF  = 1'b1;
                kill_d  = 1'b0;
                state_d = REQ;
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (PCSrcE) stallF = 1'b0;
                if (imem_req_ready) begin
                    state_d = (kill_q || PCSrcE) ? DROP : WAIT;
                    kill_d  = 1'b0;
                end else if (PCSrcE) begin
                    kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (PCSrcE) begin
                    stallF = 1'b0;
                    if (imem_rsp_valid) begin
                        state_d   = REQ;
                        enter_req = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_rsp_valid) begin
                    InstrF       = imem_rsp_data;
                    InstrF_valid = 1'b1;
                    if (stall_hz) begin
                        hold_d  = imem_rsp_data;
                        state_d = HOLD;
                    end else begin
                        stallF    = 1'b0;
                        state_d   = REQ;
                        enter_req = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    stallF    = 1'b0;
                    state_d   = REQ;
                    enter_req = 1'b1;
                end else begin
                    InstrF       = hold_q;
                    InstrF_valid = 1'b1;
                    if (!stall_hz) begin
                        stallF    = 1'b0;
                        state_d   = REQ;
                        enter_req = 1'b1;
                    end
                end
            end
            DROP: begin
                if (PCSrcE) stallF = 1'b0;
                if (imem_rsp_valid) begin
                    state_d   = REQ;
                    enter_req = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase

        // The next request address is whatever PCF holds after this edge.
        if (enter_req) addr_d = stallF ? PCF : PCNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            addr_q  <= '0;
            hold_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            kill_q  <= kill_d;
        end
    end

    // A response left over from before reset may arrive before the first new accept; tolerate it.
    logic seen_accept_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_accept_q <= 1'b0;
        end else if (imem_req_valid && imem_req_ready) begin
            seen_accept_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && seen_accept_q && imem_rsp_valid) begin
            assert (state_q == WAIT || state_q == DROP);
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stallF && !FlushF && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, redirect/reset corner sequences, random vs model.
// Define FETCH_STALL_CNT_EN to also check perf_stall_cnt.
module tb_fetch_ctrl;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        stall_hz;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] PCNext;
    logic        stallF;
    logic        FlushF;
    logic [31:0] InstrF;
    logic        InstrF_valid;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    fetch_ctrl #(.IW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PCF            (PCF),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .stall_hz       (stall_hz),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PCNext         (PCNext),
        .stallF         (stallF),
        .FlushF         (FlushF),
        .InstrF         (InstrF),
`ifdef FETCH_STALL_CNT_EN
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .InstrF_valid   (InstrF_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Tracks the presented request, the single in-flight request, and a parked instruction.
    logic        m_boot, m_req_on, m_req_dead, m_flight, m_flight_dead, m_held;
    logic [31:0] m_req_a, m_held_d, m_pcf, m_cnt;
    logic        e_reqv, e_valid, e_stall, e_flush;
    logic [31:0] e_addr, e_instr, e_pcnext;
    int          rsp_wait;
    logic [31:0] rsp_addr;
    int          lat_fix = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic model_reset();
        m_boot = 1'b1; m_req_on = 1'b0; m_req_dead = 1'b0; m_flight = 1'b0;
        m_flight_dead = 1'b0; m_held = 1'b0; m_held_d = '0; m_req_a = '0;
        m_pcf = 32'h40; m_cnt = '0; rsp_wait = -1;
    endtask

    task automatic predict();
        e_pcnext = PCSrcE ? PCTargetE : m_pcf + 32'd4;
        e_reqv   = !m_boot && m_req_on;
        e_addr   = m_req_a;
        e_flush  = m_boot;
        e_valid  = 1'b0;
        e_instr  = INSTR_NOP;
        if (!m_boot && !PCSrcE) begin
            if (m_held) begin
                e_valid = 1'b1; e_instr = m_held_d;
            end else if (m_flight && imem_rsp_valid && !m_flight_dead) begin
                e_valid = 1'b1; e_instr = imem_rsp_data;
            end
        end
        e_stall = m_boot ? 1'b1 : !(PCSrcE || (e_valid && !stall_hz));
    endtask

    task automatic advance();
        logic done = 1'b0;
        if (e_stall && !e_flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (m_boot) begin
            m_boot = 1'b0; m_req_on = 1'b1; m_req_dead = 1'b0; m_req_a = '0; m_pcf = '0;
        end else begin
            if (m_req_on) begin
                if (imem_req_ready) begin
                    m_req_on = 1'b0; m_flight = 1'b1; m_flight_dead = m_req_dead | PCSrcE;
                    rsp_wait = (lat_fix < 0) ? int'($urandom_range(0, 2)) : lat_fix;
                    rsp_addr = m_req_a;
                end else begin
                    m_req_dead = m_req_dead | PCSrcE;
                end
            end else if (m_flight) begin
                if (imem_rsp_valid) begin
                    m_flight = 1'b0;
                    if (!m_flight_dead && !PCSrcE && stall_hz) begin
                        m_held = 1'b1; m_held_d = imem_rsp_data;
                    end else begin
                        done = 1'b1;
                    end
                end else if (PCSrcE) begin
                    m_flight_dead = 1'b1;
                end
            end else if (m_held) begin
                if (PCSrcE || !stall_hz) begin
                    m_held = 1'b0; done = 1'b1;
                end
            end
            if (!e_stall) m_pcf = e_pcnext;
            if (done) begin
                m_req_on = 1'b1; m_req_dead = 1'b0; m_req_a = m_pcf;
            end
        end
    endtask

    // One clock: predict, compare mid-cycle, advance model at the edge, drive next-cycle inputs.
    task automatic step();
        predict();
        #3;
        chk("req_valid", imem_req_valid, e_reqv);
        chk("req_addr", imem_req_addr, e_addr);
        chk("instr_valid", InstrF_valid, e_valid);
        chk("instr", InstrF, e_instr);
        chk("stallF", stallF, e_stall);
        chk("FlushF", FlushF, e_flush);
        chk("PCNext", PCNext, e_pcnext);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", perf_stall_cnt, m_cnt);
`endif
        if (InstrF_valid === 1'b1) valid_seen++;
        @(posedge clk);
        advance();
        #1;
        PCF = m_pcf;
        imem_rsp_valid = (rsp_wait == 0);
        imem_rsp_data  = (rsp_wait == 0) ? mem_word(rsp_addr) : 32'h0;
        if (rsp_wait >= 0) rsp_wait--;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; stall_hz = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        model_reset();
        PCF = m_pcf;
        @(posedge clk);
        #3;
        chk("rst.req_valid", imem_req_valid, 1'b0);
        chk("rst.req_addr", imem_req_addr, 32'h0);
        chk("rst.instr_valid", InstrF_valid, 1'b0);
        chk("rst.instr", InstrF, INSTR_NOP);
        chk("rst.stallF", stallF, 1'b1);
        chk("rst.FlushF", FlushF, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        pcsrc;
        logic [31:0] tgt;
        logic        stall;
        logic        ready;
        logic        rsp;
        logic [31:0] data;
        logic [31:0] pcf;
        logic        reqv;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic        stallf;
        logic        flush;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic st, input logic rdy, input logic rsp,
                                input logic [31:0] data, input logic [31:0] pcf,
                                input logic reqv, input logic [31:0] addr, input logic valid,
                                input logic [31:0] instr, input logic stf, input logic fl);
        vec_t v;
        v.pcsrc = 1'b0; v.tgt = 32'h0; v.stall = st; v.ready = rdy; v.rsp = rsp; v.data = data;
        v.pcf = pcf; v.reqv = reqv; v.addr = addr; v.valid = valid; v.instr = instr;
        v.stallf = stf; v.flush = fl;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] nop = INSTR_NOP;
        int          n;
        // Boot, three zero-wait fetches, a 4-cycle ready stall, then a 3-cycle decode stall.
        tbl[0]  = mk(0, 1, 0, 0,            32'h40, 0, 32'h0,  0, nop,          1, 1);
        tbl[1]  = mk(0, 1, 0, 0,            32'h0,  1, 32'h0,  0, nop,          1, 0);
        tbl[2]  = mk(0, 1, 1, 32'h0010_0093, 32'h0, 0, 32'h0,  1, 32'h0010_0093, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0,            32'h4,  1, 32'h4,  0, nop,          1, 0);
        tbl[4]  = mk(0, 1, 1, 32'h0020_0113, 32'h4, 0, 32'h4,  1, 32'h0020_0113, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0,            32'h8,  1, 32'h8,  0, nop,          1, 0);
        tbl[6]  = mk(0, 1, 1, 32'h0030_0193, 32'h8, 0, 32'h8,  1, 32'h0030_0193, 0, 0);
        for (int i = 7; i < 11; i++) tbl[i] = mk(0, 0, 0, 0, 32'hC, 1, 32'hC, 0, nop, 1, 0);
        tbl[11] = mk(0, 1, 0, 0,            32'hC,  1, 32'hC,  0, nop,          1, 0);
        tbl[12] = mk(0, 1, 0, 0,            32'hC,  0, 32'hC,  0, nop,          1, 0);
        tbl[13] = mk(1, 0, 1, 32'h0000_0093, 32'hC, 0, 32'hC,  1, 32'h0000_0093, 1, 0);
        tbl[14] = mk(1, 0, 0, 0,            32'hC,  0, 32'hC,  1, 32'h0000_0093, 1, 0);
        tbl[15] = mk(1, 0, 0, 0,            32'hC,  0, 32'hC,  1, 32'h0000_0093, 1, 0);
        tbl[16] = mk(0, 0, 0, 0,            32'hC,  0, 32'hC,  1, 32'h0000_0093, 0, 0);
        tbl[17] = mk(0, 1, 0, 0,            32'h10, 1, 32'h10, 0, nop,          1, 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            PCSrcE = tbl[i].pcsrc; PCTargetE = tbl[i].tgt; stall_hz = tbl[i].stall;
            imem_req_ready = tbl[i].ready; imem_rsp_valid = tbl[i].rsp;
            imem_rsp_data = tbl[i].data; PCF = tbl[i].pcf;
            #3;
            chk($sformatf("vec%0d.req_valid", i), imem_req_valid, tbl[i].reqv);
            chk($sformatf("vec%0d.req_addr", i), imem_req_addr, tbl[i].addr);
            chk($sformatf("vec%0d.instr_valid", i), InstrF_valid, tbl[i].valid);
            chk($sformatf("vec%0d.instr", i), InstrF, tbl[i].instr);
            chk($sformatf("vec%0d.stallF", i), stallF, tbl[i].stallf);
            chk($sformatf("vec%0d.FlushF", i), FlushF, tbl[i].flush);
            chk($sformatf("vec%0d.PCNext", i), PCNext,
                tbl[i].pcsrc ? tbl[i].tgt : tbl[i].pcf + 32'd4);
            @(posedge clk);
            #1;
        end

        // Redirect while waiting with no response: stale response dropped, refetch at target.
        do_reset();
        imem_req_ready = 1'b1; lat_fix = 2;
        n = 0;
        while (n < 20 && !(m_flight && !m_flight_dead && !imem_rsp_valid)) begin step(); n++; end
        chk("t4.reach_wait", {31'b0, m_flight}, 32'h1);
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        n = valid_seen;
        step();
        PCSrcE = 1'b0;
        for (int i = 0; i < 10 && !m_req_on; i++) step();
        chk("t4.no_stale_instr", valid_seen - n, 32'h0);
        #1;
        chk("t4.redirect_valid", imem_req_valid, 1'b1);
        chk("t4.redirect_addr", imem_req_addr, 32'h100);

        // Redirect in the same cycle as a response.
        lat_fix = 1;
        n = 0;
        while (n < 20 && !(m_flight && !m_flight_dead && imem_rsp_valid)) begin step(); n++; end
        chk("t5a.reach_rsp", {31'b0, imem_rsp_valid}, 32'h1);
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        step();
        PCSrcE = 1'b0;
        #1;
        chk("t5a.redirect_valid", imem_req_valid, 1'b1);
        chk("t5a.redirect_addr", imem_req_addr, 32'h200);
        chk("t5a.discarded", InstrF_valid, 1'b0);

        // Redirect while holding a stalled instruction.
        n = 0;
        while (n < 20 && !(m_flight && !m_flight_dead && imem_rsp_valid)) begin step(); n++; end
        stall_hz = 1'b1;
        step();
        #1;
        chk("t5b.holding", InstrF_valid, 1'b1);
        PCSrcE = 1'b1; PCTargetE = 32'h300;
        step();
        PCSrcE = 1'b0; stall_hz = 1'b0;
        #1;
        chk("t5b.redirect_valid", imem_req_valid, 1'b1);
        chk("t5b.redirect_addr", imem_req_addr, 32'h300);
        chk("t5b.hold_dropped", InstrF_valid, 1'b0);

        // Reset while a request is in flight; its late response arrives during BOOT.
        lat_fix = 2;
        n = 0;
        while (n < 20 && !(m_flight && rsp_wait > 0)) begin step(); n++; end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.async_flush", FlushF, 1'b1);
        chk("t6.async_req_valid", imem_req_valid, 1'b0);
        model_reset();
        PCSrcE = 1'b0; imem_rsp_valid = 1'b0; PCF = m_pcf;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        step();
        #1;
        chk("t6.boot_req_valid", imem_req_valid, 1'b1);
        chk("t6.boot_req_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 12; i++) step();

        // Randomised traffic against the model.
        lat_fix = -1;
        for (int i = 0; i < 2500; i++) begin
            PCSrcE         = ($urandom_range(0, 7) == 0);
            PCTargetE      = $urandom() & 32'hFFFF_FFFC;
            stall_hz       = ($urandom_range(0, 2) == 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
